// File: rtl/key_stream_loader_pkg.sv
// Shared definitions for the key stream loader.
//   - FSM state encodings (NO_KEY, LOADING, KEY_READY)
//   - default word width and key slot count
//   - slot_lsb(): bit offset of a key slot inside the flattened key
package key_stream_loader_pkg;

    localparam int unsigned DefaultDataW    = 32;
    localparam int unsigned DefaultNumWords = 4;

    localparam logic [1:0] StNoKey    = 2'd0;
    localparam logic [1:0] StLoading  = 2'd1;
    localparam logic [1:0] StKeyReady = 2'd2;

    // Slot i occupies key[slot_lsb(i, w) +: w].
    function automatic int unsigned slot_lsb(input int unsigned slot, input int unsigned width);
        return slot * width;
    endfunction

endpackage

// File: rtl/key_slot_bank.sv
// NUM_WORDS x DATA_W key register array.
//   clk, rst : clock, asynchronous active-high reset (clears all slots)
//   we       : write enable for slot idx
//   idx      : slot to write
//   wdata    : word written into slot idx
//   key      : flattened key, slot i at bits [i*DATA_W +: DATA_W]
module key_slot_bank
    import key_stream_loader_pkg::*;
#(
    parameter int unsigned DATA_W    = DefaultDataW,
    parameter int unsigned NUM_WORDS = DefaultNumWords,
    parameter int unsigned IDX_W     = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        we,
    input  logic [IDX_W-1:0]            idx,
    input  logic [DATA_W-1:0]           wdata,
    output logic [DATA_W*NUM_WORDS-1:0] key
);

    logic [DATA_W-1:0] slot_q [NUM_WORDS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(NUM_WORDS); i++) begin
                slot_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(NUM_WORDS); i++) begin
                if (we && (idx == IDX_W'(i))) begin
                    slot_q[i] <= wdata;
                end
            end
        end
    end

    for (genvar g = 0; g < int'(NUM_WORDS); g++) begin : g_pack
        assign key[slot_lsb(g, DATA_W) +: DATA_W] = slot_q[g];
    end

endmodule

// File: rtl/key_stream_loader.sv
// Front-end demux between the input word stream and the crypto core.
// Key words (key_config=1) fill the key slot bank; data words (key_config=0)
// pass through a one-deep output register, but only while a full key is held.
//   clk, rst   : clock, asynchronous active-high reset
//   in_valid   : input word present
//   key_config : 1 = key material, 0 = data
//   in_data    : input word
//   in_ready   : word accepted when in_valid & in_ready at a clk edge
//   out_valid  : output register holds a data word
//   out_data   : registered data word
//   out_ready  : downstream accepts out_data
//   key        : assembled key
//   key_valid  : complete key held
//   key_idx    : next slot to be written
//   key_err    : one-cycle pulse when a data word aborts a partial load
module key_stream_loader
    import key_stream_loader_pkg::*;
#(
    parameter int unsigned DATA_W    = DefaultDataW,
    parameter int unsigned NUM_WORDS = DefaultNumWords,
    parameter int unsigned IDX_W     = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    input  logic                        key_config,
    input  logic [DATA_W-1:0]           in_data,
    output logic                        in_ready,
    output logic                        out_valid,
    output logic [DATA_W-1:0]           out_data,
    input  logic                        out_ready,
    output logic [DATA_W*NUM_WORDS-1:0] key,
    output logic                        key_valid,
    output logic [IDX_W-1:0]            key_idx,
    output logic                        key_err
);

    logic [1:0]        state_q, state_d;
    logic [IDX_W-1:0]  key_idx_q, key_idx_d;
    logic              key_err_q;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;

    logic key_we;
    logic data_ready;
    logic data_acc;
    logic abort;
    logic last_slot;

    always_comb begin
        data_ready = (state_q == StKeyReady) && (!out_valid_q || out_ready);
        in_ready   = key_config || data_ready;
        key_we     = in_valid && key_config;
        data_acc   = in_valid && !key_config && data_ready;
        // A data word during a partial load aborts it; the word itself stalls.
        abort      = in_valid && !key_config && (state_q == StLoading);
        last_slot  = (key_idx_q == IDX_W'(NUM_WORDS - 1));
    end

    always_comb begin
        state_d   = state_q;
        key_idx_d = key_idx_q;
        if (state_q == 2'd3) begin
            state_d = StNoKey;
        end
        if (key_we) begin
            // From KEY_READY key_idx_q is already 0, so a reload starts at slot 0.
            if (last_slot) begin
                key_idx_d = '0;
                state_d   = StKeyReady;
            end else begin
                key_idx_d = key_idx_q + 1'b1;
                state_d   = StLoading;
            end
        end else if (abort) begin
            key_idx_d = '0;
            state_d   = StNoKey;
        end
    end

    // Output register is independent of the key FSM so a pending word drains
    // even while a reload is in progress.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (data_acc) begin
            out_valid_d = 1'b1;
            out_data_d  = in_data;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StNoKey;
            key_idx_q   <= '0;
            key_err_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            key_idx_q   <= key_idx_d;
            key_err_q   <= abort;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    key_slot_bank #(
        .DATA_W    (DATA_W),
        .NUM_WORDS (NUM_WORDS),
        .IDX_W     (IDX_W)
    ) u_key_slot_bank (
        .clk   (clk),
        .rst   (rst),
        .we    (key_we),
        .idx   (key_idx_q),
        .wdata (in_data),
        .key   (key)
    );

    assign key_valid = (state_q == StKeyReady);
    assign key_idx   = key_idx_q;
    assign key_err   = key_err_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_key_stream_loader.sv
module tb_key_stream_loader;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         key_config;
    logic [31:0]  in_data;
    logic         in_ready;
    logic         out_valid;
    logic [31:0]  out_data;
    logic         out_ready;
    logic [127:0] key;
    logic         key_valid;
    logic [1:0]   key_idx;
    logic         key_err;

    int total = 0;
    int bad   = 0;

    key_stream_loader dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .key_config (key_config),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .key        (key),
        .key_valid  (key_valid),
        .key_idx    (key_idx),
        .key_err    (key_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic         v;
        logic         kc;
        logic [31:0]  d;
        logic         ordy;
        logic         ir;
        logic         ov;
        logic [31:0]  od;
        logic         kv;
        logic [1:0]   ki;
        logic         ke;
        logic [127:0] k;
    } vec_t;

    function automatic vec_t mk(logic v, logic kc, logic [31:0] d, logic ordy, logic ir,
                                logic ov, logic [31:0] od, logic kv, logic [1:0] ki,
                                logic ke, logic [127:0] k);
        vec_t t;
        t.v = v; t.kc = kc; t.d = d; t.ordy = ordy; t.ir = ir; t.ov = ov; t.od = od;
        t.kv = kv; t.ki = ki; t.ke = ke; t.k = k;
        return t;
    endfunction

    // Reference model: key as an array of words plus a "complete key held"
    // flag, a "partial load in progress" flag and a one-entry output buffer.
    logic [31:0] m_slot [4];
    int          m_next;
    bit          m_complete;
    bit          m_partial;
    bit          m_ov;
    logic [31:0] m_od;
    bit          m_err;

    function automatic logic [127:0] m_key();
        return {m_slot[3], m_slot[2], m_slot[1], m_slot[0]};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_slot[i] = '0;
        m_next = 0; m_complete = 0; m_partial = 0; m_ov = 0; m_od = '0; m_err = 0;
    endtask

    task automatic model_step(input bit v, input bit kc, input logic [31:0] d, input bit ordy);
        bit take_data;
        take_data = v && !kc && m_complete && (!m_ov || ordy);
        m_err = v && !kc && m_partial;
        if (v && kc) begin
            m_slot[m_next] = d;
            m_next = (m_next + 1) % 4;
            m_complete = (m_next == 0);
            m_partial  = (m_next != 0);
        end else if (m_err) begin
            m_partial = 0;
            m_next = 0;
        end
        if (take_data) begin
            m_ov = 1; m_od = d;
        end else if (ordy) begin
            m_ov = 0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0; key_config = 1'b0; in_data = '0; out_ready = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    // Drive inputs (we sit just after a rising edge), check in_ready, clock, check state.
    task automatic step_model(input bit v, input bit kc, input logic [31:0] d, input bit ordy);
        in_valid = v; key_config = kc; in_data = d; out_ready = ordy;
        #1;
        chk("in_ready", in_ready, kc ? 1'b1 : (m_complete && (!m_ov || ordy)));
        @(posedge clk);
        model_step(v, kc, d, ordy);
        #1;
        chk("out_valid", out_valid, m_ov);
        if (m_ov) chk("out_data", out_data, m_od);
        chk("key_valid", key_valid, m_complete);
        chk("key_idx", key_idx, m_next[1:0]);
        chk("key_err", key_err, m_err);
        chk("key", key, m_key());
    endtask

    localparam logic [127:0] K1 = 128'h44444444_33333333_22222222_11111111;
    localparam logic [127:0] K2 = 128'h44444444_33333333_22222222_AAAAAAAA;
    localparam logic [127:0] K3 = 128'h44444444_33333333_BBBBBBBB_AAAAAAAA;
    localparam logic [127:0] K4 = 128'h44444444_33333333_BBBBBBBB_11111111;
    localparam logic [127:0] K5 = 128'h44444444_33333333_22222222_CCCCCCCC;

    vec_t tbl[$];

    initial begin
        // v kc data ordy | ir ov od kv ki ke key
        tbl.push_back(mk(1, 0, 32'hDEADBEEF, 1, 0, 0, 32'h0, 0, 0, 0, 128'h0));
        tbl.push_back(mk(1, 0, 32'hDEADBEEF, 1, 0, 0, 32'h0, 0, 0, 0, 128'h0));
        tbl.push_back(mk(1, 1, 32'h11111111, 1, 1, 0, 32'h0, 0, 1, 0, 128'h11111111));
        tbl.push_back(mk(1, 1, 32'h22222222, 1, 1, 0, 32'h0, 0, 2, 0,
                         128'h22222222_11111111));
        tbl.push_back(mk(1, 1, 32'h33333333, 1, 1, 0, 32'h0, 0, 3, 0,
                         128'h33333333_22222222_11111111));
        tbl.push_back(mk(1, 1, 32'h44444444, 1, 1, 0, 32'h0, 1, 0, 0, K1));
        tbl.push_back(mk(1, 0, 32'hDEADBEEF, 1, 1, 1, 32'hDEADBEEF, 1, 0, 0, K1));
        tbl.push_back(mk(1, 0, 32'h00000001, 1, 1, 1, 32'h00000001, 1, 0, 0, K1));
        tbl.push_back(mk(1, 0, 32'h00000002, 0, 0, 1, 32'h00000001, 1, 0, 0, K1));
        tbl.push_back(mk(1, 0, 32'h00000002, 0, 0, 1, 32'h00000001, 1, 0, 0, K1));
        tbl.push_back(mk(1, 0, 32'h00000002, 1, 1, 1, 32'h00000002, 1, 0, 0, K1));
        tbl.push_back(mk(1, 0, 32'h00000003, 1, 1, 1, 32'h00000003, 1, 0, 0, K1));
        tbl.push_back(mk(0, 0, 32'h0,        1, 1, 0, 32'h00000003, 1, 0, 0, K1));
        tbl.push_back(mk(1, 1, 32'hAAAAAAAA, 1, 1, 0, 32'h00000003, 0, 1, 0, K2));
        tbl.push_back(mk(1, 1, 32'hBBBBBBBB, 1, 1, 0, 32'h00000003, 0, 2, 0, K3));
        tbl.push_back(mk(1, 0, 32'h00000005, 1, 0, 0, 32'h00000003, 0, 0, 1, K3));
        tbl.push_back(mk(0, 0, 32'h0,        1, 0, 0, 32'h00000003, 0, 0, 0, K3));
        tbl.push_back(mk(1, 1, 32'h11111111, 1, 1, 0, 32'h00000003, 0, 1, 0, K4));
        tbl.push_back(mk(1, 1, 32'h22222222, 1, 1, 0, 32'h00000003, 0, 2, 0, K1));
        tbl.push_back(mk(1, 1, 32'h33333333, 1, 1, 0, 32'h00000003, 0, 3, 0, K1));
        tbl.push_back(mk(1, 1, 32'h44444444, 1, 1, 0, 32'h00000003, 1, 0, 0, K1));
        tbl.push_back(mk(1, 0, 32'h00000005, 1, 1, 1, 32'h00000005, 1, 0, 0, K1));
        tbl.push_back(mk(1, 1, 32'hCCCCCCCC, 0, 1, 1, 32'h00000005, 0, 1, 0, K5));
        tbl.push_back(mk(0, 0, 32'h0,        1, 0, 0, 32'h00000005, 0, 1, 0, K5));

        // Reset values, checked while rst is held.
        rst = 1'b1;
        in_valid = 1'b0; key_config = 1'b0; in_data = '0; out_ready = 1'b0;
        #2;
        chk("rst_in_ready_data", in_ready, 1'b0);
        key_config = 1'b1;
        #1;
        chk("rst_in_ready_key", in_ready, 1'b1);
        key_config = 1'b0;
        chk("rst_key", key, 128'h0);
        chk("rst_key_valid", key_valid, 1'b0);
        chk("rst_key_idx", key_idx, 2'd0);
        chk("rst_key_err", key_err, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Directed table.
        for (int i = 0; i < tbl.size(); i++) begin
            vec_t t;
            t = tbl[i];
            in_valid = t.v; key_config = t.kc; in_data = t.d; out_ready = t.ordy;
            #1;
            chk($sformatf("row%0d_in_ready", i), in_ready, t.ir);
            @(posedge clk);
            #1;
            chk($sformatf("row%0d_out_valid", i), out_valid, t.ov);
            chk($sformatf("row%0d_out_data", i), out_data, t.od);
            chk($sformatf("row%0d_key_valid", i), key_valid, t.kv);
            chk($sformatf("row%0d_key_idx", i), key_idx, t.ki);
            chk($sformatf("row%0d_key_err", i), key_err, t.ke);
            chk($sformatf("row%0d_key", i), key, t.k);
        end

        // Async reset mid-load (key_idx=2): outputs clear before the next edge.
        do_reset();
        step_model(1, 1, 32'h01020304, 1);
        step_model(1, 1, 32'h05060708, 1);
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("arst_load_key_idx", key_idx, 2'd0);
        chk("arst_load_key", key, 128'h0);
        chk("arst_load_key_valid", key_valid, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();

        // Async reset with a word pending in the output register.
        for (int i = 0; i < 4; i++) step_model(1, 1, $urandom, 1);
        step_model(1, 0, 32'hFEEDF00D, 0);
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("arst_xfer_out_valid", out_valid, 1'b0);
        chk("arst_xfer_out_data", out_data, 32'h0);
        chk("arst_xfer_key_valid", key_valid, 1'b0);
        chk("arst_xfer_key", key, 128'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();

        // Randomized traffic against the reference model.
        for (int n = 0; n < 3000; n++) begin
            bit v, kc, ordy;
            v    = ($urandom_range(0, 3) != 0);
            kc   = ($urandom_range(0, 2) == 0);
            ordy = ($urandom_range(0, 3) != 0);
            step_model(v, kc, $urandom, ordy);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
